// File: rtl/i2c_controller.sv
// Single-byte I2C initiator: START, {addr,rw}, target ACK, one data byte, ACK/NACK, STOP.
// Line outputs are registered and decoded from next-state values so they change with the state.
module i2c_controller #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       rw,
    input  logic [6:0] addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       ack_error,
    output logic       scl_out,
    output logic       sda_out,
    output logic       sda_oe,
    input  logic       sda_in
);
    typedef enum logic [2:0] {
        IDLE, START, ADDR, ADDR_ACK, DATA, DATA_ACK, STOP, DONE
    } state_t;

    localparam logic [7:0] QMAX = 8'(CLK_DIV - 1);

    state_t     state_q, state_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic [1:0] quarter_q, quarter_d;
    logic [2:0] bit_q, bit_d;
    logic [7:0] abyte_q, abyte_d;
    logic [7:0] wdata_q, wdata_d;
    logic [7:0] rdata_q, rdata_d;
    logic       ack_error_q, ack_error_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       scl_q, scl_d;
    logic       sda_q, sda_d;
    logic       oe_q, oe_d;
    logic       quarter_end, slot_end, sample;

    always_comb begin
        quarter_end = (qcnt_q == QMAX);
        slot_end    = quarter_end && (quarter_q == 2'd3);
        sample      = quarter_end && (quarter_q == 2'd2);

        state_d     = state_q;
        qcnt_d      = qcnt_q;
        quarter_d   = quarter_q;
        bit_d       = bit_q;
        abyte_d     = abyte_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        ack_error_d = ack_error_q;

        if (state_q == IDLE || state_q == DONE) begin
            state_d = IDLE;
            if (start) begin
                state_d     = START;
                qcnt_d      = 8'd0;
                quarter_d   = 2'd0;
                bit_d       = 3'd0;
                abyte_d     = {addr, rw};
                wdata_d     = wdata;
                ack_error_d = 1'b0;
            end
        end else begin
            qcnt_d = quarter_end ? 8'd0 : qcnt_q + 8'd1;
            if (quarter_end) quarter_d = quarter_q + 2'd1;

            // abyte_q[0] is the latched R/W bit
            if (sample) begin
                case (state_q)
                    ADDR_ACK: if (sda_in) ack_error_d = 1'b1;
                    DATA:     if (abyte_q[0]) rdata_d = {rdata_q[6:0], sda_in};
                    DATA_ACK: if (!abyte_q[0] && sda_in) ack_error_d = 1'b1;
                    default:  ;
                endcase
            end

            if (slot_end) begin
                case (state_q)
                    START:    state_d = ADDR;
                    ADDR: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = ADDR_ACK;
                    end
                    ADDR_ACK: state_d = ack_error_q ? STOP : DATA;
                    DATA: begin
                        bit_d = bit_q + 3'd1;
                        if (bit_q == 3'd7) state_d = DATA_ACK;
                    end
                    DATA_ACK: state_d = STOP;
                    STOP:     state_d = DONE;
                    default:  state_d = IDLE;
                endcase
            end
        end

        busy_d = !(state_d == IDLE || state_d == DONE);
        done_d = (state_d == DONE);
        scl_d  = 1'b1;
        sda_d  = 1'b1;
        oe_d   = 1'b0;
        case (state_d)
            START: begin
                oe_d  = 1'b1;
                sda_d = !quarter_d[1];
            end
            ADDR: begin
                scl_d = quarter_d[1];
                oe_d  = 1'b1;
                sda_d = abyte_d[3'd7 - bit_d];
            end
            ADDR_ACK: scl_d = quarter_d[1];
            DATA: begin
                scl_d = quarter_d[1];
                oe_d  = !abyte_d[0];
                sda_d = abyte_d[0] ? 1'b1 : wdata_d[3'd7 - bit_d];
            end
            // a read ends with the controller driving NACK (sda stays 1)
            DATA_ACK: begin
                scl_d = quarter_d[1];
                oe_d  = abyte_d[0];
            end
            STOP: begin
                scl_d = quarter_d[1];
                oe_d  = 1'b1;
                sda_d = (quarter_d == 2'd3);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            qcnt_q      <= 8'd0;
            quarter_q   <= 2'd0;
            bit_q       <= 3'd0;
            rdata_q     <= 8'd0;
            ack_error_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            scl_q       <= 1'b1;
            sda_q       <= 1'b1;
            oe_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            qcnt_q      <= qcnt_d;
            quarter_q   <= quarter_d;
            bit_q       <= bit_d;
            rdata_q     <= rdata_d;
            ack_error_q <= ack_error_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            scl_q       <= scl_d;
            sda_q       <= sda_d;
            oe_q        <= oe_d;
        end
    end

    // request operands are only consumed while busy, so they need no reset
    always_ff @(posedge clk) begin
        abyte_q <= abyte_d;
        wdata_q <= wdata_d;
    end

    assign rdata     = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign ack_error = ack_error_q;
    assign scl_out   = scl_q;
    assign sda_out   = sda_q;
    assign sda_oe    = oe_q;
endmodule

// File: tb/tb_i2c_controller.sv
// Bench for i2c_controller: two instances (CLK_DIV=4 and CLK_DIV=1) share one I2C target model
// and bus monitor; expected transactions are queued at request time and checked at done.
`timescale 1ns/1ps
module tb_i2c_controller;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       rw    = 1'b0;
    logic [6:0] addr  = 7'd0;
    logic [7:0] wdata = 8'd0;
    logic       sel   = 1'b0;

    logic       start4, start1;
    logic [7:0] rdata4, rdata1;
    logic       busy4, busy1, done4, done1, aerr4, aerr1;
    logic       scl4, scl1, out4, out1, oe4, oe1, line4, line1;

    logic       tgt_sda  = 1'b1;
    logic       tb_read  = 1'b0;
    logic       tb_ack_a = 1'b1;
    logic       tb_ack_d = 1'b1;
    logic [7:0] tb_rbyte = 8'd0;

    assign start4 = start & ~sel;
    assign start1 = start & sel;
    assign line4  = (oe4 ? out4 : 1'b1) & (sel ? 1'b1 : tgt_sda);
    assign line1  = (oe1 ? out1 : 1'b1) & (sel ? tgt_sda : 1'b1);

    i2c_controller #(.CLK_DIV(4)) dut4 (
        .clk(clk), .reset(reset), .start(start4), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata4), .busy(busy4), .done(done4), .ack_error(aerr4),
        .scl_out(scl4), .sda_out(out4), .sda_oe(oe4), .sda_in(line4));

    i2c_controller #(.CLK_DIV(1)) dut1 (
        .clk(clk), .reset(reset), .start(start1), .rw(rw), .addr(addr), .wdata(wdata),
        .rdata(rdata1), .busy(busy1), .done(done1), .ack_error(aerr1),
        .scl_out(scl1), .sda_out(out1), .sda_oe(oe1), .sda_in(line1));

    logic       m_scl, m_line, m_oe, m_out, m_busy, m_done, m_aerr;
    logic [7:0] m_rdata;
    assign m_scl   = sel ? scl1   : scl4;
    assign m_line  = sel ? line1  : line4;
    assign m_oe    = sel ? oe1    : oe4;
    assign m_out   = sel ? out1   : out4;
    assign m_busy  = sel ? busy1  : busy4;
    assign m_done  = sel ? done1  : done4;
    assign m_aerr  = sel ? aerr1  : aerr4;
    assign m_rdata = sel ? rdata1 : rdata4;

    // Bus monitor and target: slot index advances on each SCL fall after a START condition.
    int         cyc = 0, idx = 100, nrise = 0, gap = 0, last_rise = 0, done_cnt = 0;
    logic       scl_p = 1'b1, line_p = 1'b1, stop_seen = 1'b0, oe17 = 1'b0, out17 = 1'b0;
    logic [7:0] addr_sh = 8'd0, data_sh = 8'd0;

    function automatic logic plan(int i);
        if (i == 8) return !tb_ack_a;
        if (i >= 9 && i <= 16 && tb_read && tb_ack_a) return tb_rbyte[16 - i];
        if (i == 17 && !tb_read && tb_ack_a) return !tb_ack_d;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        cyc    <= cyc + 1;
        scl_p  <= m_scl;
        line_p <= m_line;
        if (m_done) done_cnt <= done_cnt + 1;
        if (scl_p && m_scl && line_p && !m_line) begin
            idx <= -1; nrise <= 0; stop_seen <= 1'b0; addr_sh <= 8'd0; data_sh <= 8'd0;
            oe17 <= 1'b0; out17 <= 1'b0; tgt_sda <= 1'b1;
        end else if (scl_p && m_scl && !line_p && m_line) begin
            stop_seen <= 1'b1;
        end
        if (scl_p && !m_scl) begin
            idx     <= idx + 1;
            tgt_sda <= plan(idx + 1);
        end
        if (!scl_p && m_scl) begin
            nrise     <= nrise + 1;
            gap       <= cyc - last_rise;
            last_rise <= cyc;
            if (idx >= 0 && idx <= 7) addr_sh <= {addr_sh[6:0], m_line};
            else if (idx >= 9 && idx <= 16) data_sh <= {data_sh[6:0], m_line};
            else if (idx == 17) begin oe17 <= m_oe; out17 <= m_out; end
        end
    end

    typedef struct packed {
        logic       sel;
        logic [6:0] a;
        logic       rw;
        logic [7:0] wd;
        logic       acka;
        logic       ackd;
        logic [7:0] rb;
    } txn_t;

    typedef struct {
        logic [7:0] abyte;
        logic [7:0] dbyte;
        logic       acka;
        logic       aerr;
        logic [7:0] rd;
        int         lat;
        int         rises;
        int         gap;
        logic       rnack;
    } exp_t;

    localparam txn_t TBL [7] = '{
        '{1'b0, 7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00},
        '{1'b0, 7'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 8'h55},
        '{1'b0, 7'h55, 1'b1, 8'h00, 1'b1, 1'b1, 8'hAA},
        '{1'b0, 7'h11, 1'b0, 8'h3C, 1'b0, 1'b1, 8'h00},
        '{1'b0, 7'h2A, 1'b0, 8'h5A, 1'b1, 1'b0, 8'h00},
        '{1'b1, 7'h55, 1'b0, 8'hC3, 1'b1, 1'b1, 8'h00},
        '{1'b1, 7'h2A, 1'b1, 8'h00, 1'b1, 1'b1, 8'h96}
    };

    exp_t       exp_q [$];
    logic [7:0] rd_model [2] = '{8'h00, 8'h00};
    int         tests = 0, fails = 0;

    function automatic exp_t make_exp(txn_t t);
        exp_t e;
        e.abyte = {t.a, t.rw};
        e.dbyte = t.rw ? t.rb : t.wd;
        e.acka  = t.acka;
        e.aerr  = !t.acka || (!t.rw && !t.ackd);
        e.rd    = (t.rw && t.acka) ? t.rb : rd_model[t.sel];
        e.lat   = (t.acka ? 80 : 44) * (t.sel ? 1 : 4);
        e.rises = t.acka ? 19 : 10;
        e.gap   = 4 * (t.sel ? 1 : 4);
        e.rnack = t.rw && t.acka;
        return e;
    endfunction

    task automatic setup(input txn_t t);
        sel = t.sel; addr = t.a; rw = t.rw; wdata = t.wd;
        tb_read = t.rw; tb_ack_a = t.acka; tb_ack_d = t.ackd; tb_rbyte = t.rb;
    endtask

    task automatic kick(input bit hold);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start = 1'b0;
    endtask

    task automatic wait_done(input int lim, output int n, output bit seen);
        n = 0;
        seen = 1'b0;
        while (n < lim && !seen) begin
            @(posedge clk);
            #1;
            n++;
            seen = (m_done === 1'b1);
        end
    endtask

    task automatic test_reset();
        logic [13:0] got4, got1;
        int d0;
        repeat (3) @(posedge clk);
        #1;
        got4 = {busy4, done4, aerr4, rdata4, scl4, out4, oe4};
        got1 = {busy1, done1, aerr1, rdata1, scl1, out1, oe1};
        tests++;
        if (got4 !== 14'b000_00000000_110) begin
            fails++; $display("FAIL reset_state_div4: got %b want 00000000000110", got4);
        end
        tests++;
        if (got1 !== 14'b000_00000000_110) begin
            fails++; $display("FAIL reset_state_div1: got %b want 00000000000110", got1);
        end
        @(negedge clk);
        reset = 1'b0;

        setup('{1'b0, 7'h2A, 1'b0, 8'hA5, 1'b1, 1'b1, 8'h00});
        kick(0);
        repeat (30) @(posedge clk);
        #1;
        tests++;
        if ({m_busy, m_oe} !== 2'b11) begin
            fails++; $display("FAIL mid_addr_busy_oe: got %b want 11", {m_busy, m_oe});
        end
        #2;
        reset = 1'b1;
        #1;
        tests++;
        if ({m_scl, m_oe, m_busy} !== 3'b100) begin
            fails++; $display("FAIL async_reset_release: scl/oe/busy got %b want 100", {m_scl, m_oe, m_busy});
        end
        repeat (2) @(negedge clk);
        reset = 1'b0;
        d0 = done_cnt;
        repeat (400) @(posedge clk);
        #1;
        tests++;
        if (done_cnt != d0 || m_busy !== 1'b0) begin
            fails++; $display("FAIL no_done_after_reset: done pulses %0d busy %b want 0 0", done_cnt - d0, m_busy);
        end
    endtask

    task automatic test_transactions();
        for (int i = 0; i < 7; i++) begin
            txn_t t;
            exp_t e;
            int   n;
            bit   seen;
            t = TBL[i];
            setup(t);
            exp_q.push_back(make_exp(t));
            rd_model[t.sel] = make_exp(t).rd;
            kick(0);
            tests++;
            if (m_busy !== 1'b1) begin
                fails++; $display("FAIL busy_after_accept[%0d]: got %b want 1", i, m_busy);
            end
            wait_done(400, n, seen);
            e = exp_q.pop_front();
            tests++;
            if (!seen || n != e.lat) begin
                fails++; $display("FAIL latency[%0d]: got %0d (seen %b) want %0d", i, n, seen, e.lat);
            end
            if (seen) begin
                tests++;
                if (addr_sh !== e.abyte) begin
                    fails++; $display("FAIL addr_byte[%0d]: got %h want %h", i, addr_sh, e.abyte);
                end
                if (e.acka) begin
                    tests++;
                    if (data_sh !== e.dbyte) begin
                        fails++; $display("FAIL data_byte[%0d]: got %h want %h", i, data_sh, e.dbyte);
                    end
                end
                tests++;
                if (m_aerr !== e.aerr) begin
                    fails++; $display("FAIL ack_error[%0d]: got %b want %b", i, m_aerr, e.aerr);
                end
                tests++;
                if (m_rdata !== e.rd) begin
                    fails++; $display("FAIL rdata[%0d]: got %h want %h", i, m_rdata, e.rd);
                end
                tests++;
                if (stop_seen !== 1'b1 || nrise != e.rises || m_busy !== 1'b0) begin
                    fails++; $display("FAIL framing[%0d]: stop %b rises %0d busy %b want 1 %0d 0",
                                      i, stop_seen, nrise, m_busy, e.rises);
                end
                tests++;
                if (gap != e.gap) begin
                    fails++; $display("FAIL scl_period[%0d]: got %0d want %0d", i, gap, e.gap);
                end
                if (e.rnack) begin
                    tests++;
                    if ({oe17, out17} !== 2'b11) begin
                        fails++; $display("FAIL read_nack_drive[%0d]: oe/out got %b want 11", i, {oe17, out17});
                    end
                end
            end
            repeat (3) @(posedge clk);
        end
    endtask

    task automatic test_busy_ignore();
        txn_t t;
        exp_t e;
        int   n, d0;
        bit   seen;
        t = '{1'b0, 7'h2A, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00};
        setup(t);
        exp_q.push_back(make_exp(t));
        d0 = done_cnt;
        kick(0);
        repeat (40) @(posedge clk);
        #1;
        start = 1'b1; addr = 7'h55; rw = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(400, n, seen);
        n = n + 41;
        e = exp_q.pop_front();
        tests++;
        if (!seen || n != e.lat || addr_sh !== e.abyte || data_sh !== e.dbyte) begin
            fails++; $display("FAIL busy_ignore_txn: lat %0d addr %h data %h want %0d %h %h",
                              n, addr_sh, data_sh, e.lat, e.abyte, e.dbyte);
        end
        repeat (300) @(posedge clk);
        #1;
        tests++;
        if (done_cnt - d0 != 1 || m_busy !== 1'b0) begin
            fails++; $display("FAIL busy_ignore_count: done pulses %0d busy %b want 1 0", done_cnt - d0, m_busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            txn_t t;
            exp_t e;
            int   n;
            bit   seen;
            t = '{s[0], 7'h55, 1'b0, 8'h81, 1'b1, 1'b1, 8'h00};
            setup(t);
            exp_q.push_back(make_exp(t));
            exp_q.push_back(make_exp(t));
            kick(1);
            wait_done(400, n, seen);
            e = exp_q.pop_front();
            tests++;
            if (!seen || n != e.lat || addr_sh !== e.abyte || m_busy !== 1'b0) begin
                fails++; $display("FAIL b2b_first[%0d]: lat %0d addr %h busy %b want %0d %h 0",
                                  s, n, addr_sh, m_busy, e.lat, e.abyte);
            end
            @(posedge clk);
            #1;
            tests++;
            if ({m_busy, m_done} !== 2'b10) begin
                fails++; $display("FAIL b2b_accept_in_done[%0d]: busy/done got %b want 10", s, {m_busy, m_done});
            end
            start = 1'b0;
            wait_done(400, n, seen);
            e = exp_q.pop_front();
            tests++;
            if (!seen || n != e.lat || addr_sh !== e.abyte || data_sh !== e.dbyte) begin
                fails++; $display("FAIL b2b_second[%0d]: lat %0d addr %h data %h want %0d %h %h",
                                  s, n, addr_sh, data_sh, e.lat, e.abyte, e.dbyte);
            end
            repeat (3) @(posedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_transactions();
        test_busy_ignore();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule

// File: doc/i2c_controller.md
Name: i2c_controller

Overview:
Single-byte I2C initiator that drives SCL and SDA from the system clock. It performs one complete transaction per request: START, 7-bit address plus R/W, target ACK, one data byte, ACK/NACK, STOP. It is the host-side counterpart of i2c_periph and is used by the bench and by on-chip logic to talk to the 0x2A/0x55 peripherals.

Parameters:
CLK_DIV, 4, system clk cycles per SCL quarter-bit; legal range 1..255.

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; returns block to idle
start  input  1  request pulse; sampled only while busy=0
rw  input  1  1=read, 0=write; latched on accept
addr  input  7  target address; latched on accept
wdata  input  8  write byte; latched on accept
rdata  output  8  byte received on read; valid when done=1
busy  output  1  high from accept until transaction end
done  output  1  one-cycle completion pulse
ack_error  output  1  target NACKed address or write data; valid when done=1, held until next accept
scl_out  output  1  SCL drive value
sda_out  output  1  SDA drive value when sda_oe=1
sda_oe  output  1  1 = controller drives SDA, 0 = released
sda_in  input  1  sampled SDA line

Behaviour:
- Reset (async): busy=0, done=0, ack_error=0, rdata=0, scl_out=1, sda_out=1, sda_oe=0, state IDLE, counters 0.
- Accept: start=1 with busy=0 at rising edge E. addr/rw/wdata latched, busy=1 from E+1, ack_error cleared. start while busy=1 is ignored. No queuing.
- Timing: each bit slot is 4 quarters of CLK_DIV cycles each (q0..q3).
  - Data/ACK slots: scl_out=0 in q0,q1; scl_out=1 in q2,q3.
  - sda_out/sda_oe update at the start of q0.
  - sda_in is sampled on the last clk of q2.
- States and slot counts:
  - IDLE: waits for accept.
  - START (1 slot): scl=1 throughout; sda_oe=1; sda_out=1 in q0,q1, then 0 in q2,q3.
  - ADDR (8 slots): MSB first, {addr, rw}; sda_oe=1.
  - ADDR_ACK (1 slot): sda_oe=0; sampled 0 means ACK, 1 means NACK.
    - NACK: ack_error=1, go to STOP.
    - ACK: go to DATA.
  - DATA (8 slots), MSB first.
    - Write: drive wdata with sda_oe=1.
    - Read: sda_oe=0; shift sampled bits into rdata.
  - DATA_ACK (1 slot).
    - Write: sda_oe=0; sampled 1 sets ack_error=1.
    - Read: controller drives NACK (sda_oe=1, sda_out=1).
  - STOP (1 slot): sda_oe=1, sda_out=0 in q0..q2, sda_out=1 in q3; scl=0 in q0,q1 and 1 in q2,q3.
  - DONE: single cycle. done=1, busy=0, sda_oe=0, scl=1. Returns to IDLE next cycle; a new start is acceptable in that same DONE cycle.
- Latency from E+1 to done:
  - Full transaction: 80*CLK_DIV cycles (20 slots).
  - Address NACK: 44*CLK_DIV cycles (11 slots).
- rdata:
  - Updates only during read DATA.
  - Holds its value through writes and idle.
  - Its value after an address-NACK read is unspecified.
- Bit counter: 3-bit, wraps 7→0 on the exit of ADDR or DATA. Quarter counter counts 0..CLK_DIV-1.
- Reset mid-transaction: lines release immediately (scl=1, sda_oe=0). No STOP is generated and no done pulse is produced.
- Clock stretching and arbitration are not supported. sda_in is ignored outside the ACK and read-data slots.

Test Plan:
- Reset: reset=1 mid-ADDR with CLK_DIV=4 → same cycle scl_out=1, sda_oe=0, busy=0; no done pulse after release.
- Write: addr=0x2A, rw=0, wdata=0xA5, bench target ACKs both slots → SDA bits 0x54 then 0xA5 MSB-first, each sampled with SCL high; done at E+1+320; ack_error=0.
- Read: addr=0x2A, rw=1, target ACKs and returns 0x55 → rdata=0x55; controller drives NACK (sda_out=1, sda_oe=1) in the 9th data slot; STOP seen; ack_error=0.
- Read: addr=0x55, target returns 0xAA → rdata=0xAA.
- Address NACK: addr=0x11, target releases SDA in ADDR_ACK → no data slots, STOP follows immediately; done at E+1+176; ack_error=1.
- Busy/back-to-back: start pulsed during ADDR → ignored, one transaction only. start held high through DONE → second transaction accepted in the DONE cycle, busy high again next cycle. Repeat with CLK_DIV=1: SCL period is 4 clk.
